// File: rtl/servo_scan_ctrl.sv
// servo_scan_ctrl
//   Sweeps the servo angle from ANGLE_MIN to ANGLE_MAX in ANGLE_STEP steps.
//   At each point it waits SETTLE_CYCLES, requests an IR sample and keeps the
//   strongest one. When the sweep ends it parks the servo on the best angle,
//   waits one more settle period and pulses done.
//
//   Build option: define SCAN_AVG4_EN to take four samples per point and
//   compare their average ((sum of 4) >> 2) instead of a single sample.
//
// Ports
//   clk        : system clock, posedge
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle scan request, honoured only while idle
//   abort      : ends a running scan; results are not updated
//   ir_req     : one-cycle sample request to the IR front end
//   ir_valid   : one-cycle strobe qualifying ir_data
//   ir_data    : IR intensity sample, larger is stronger
//   angle      : angle command to the servo PWM generator
//   busy       : high in every state except idle
//   done       : one-cycle pulse once parked on the best angle
//   best_angle : angle of the strongest sample of the last completed scan
//   best_value : value of that sample (average when SCAN_AVG4_EN)
module servo_scan_ctrl #(
    parameter int ANGLE_MIN     = 0,
    parameter int ANGLE_MAX     = 180,
    parameter int ANGLE_STEP    = 5,
    parameter int ANGLE_HOME    = 90,
    parameter int SETTLE_CYCLES = 2_000_000,
    parameter int IR_W          = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic            ir_req,
    input  logic            ir_valid,
    input  logic [IR_W-1:0] ir_data,
    output logic [15:0]     angle,
    output logic            busy,
    output logic            done,
    output logic [15:0]     best_angle,
    output logic [IR_W-1:0] best_value
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_REQ,
        S_WAIT,
        S_PARK
    } state_t;

    state_t          state_q;
    logic [15:0]     angle_q;
    logic            busy_q;
    logic            done_q;
    logic            ir_req_q;
    logic [15:0]     best_angle_q;
    logic [IR_W-1:0] best_value_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     max_ang_q;
    logic [IR_W-1:0] max_val_q;

    logic [16:0]     ang_sum_d;
    logic [15:0]     ang_next_d;
    logic [IR_W-1:0] smp_d;
    logic            take_d;
    logic [15:0]     win_ang_d;
    logic [IR_W-1:0] win_val_d;

`ifdef SCAN_AVG4_EN
    logic [1:0]      k_q;
    logic [IR_W+1:0] acc_q;
    logic [IR_W+1:0] acc_sum_d;
`endif

    always_comb begin
        // 17-bit sum so a step past 0xFFFF cannot wrap below ANGLE_MAX
        ang_sum_d  = {1'b0, angle_q} + 17'(ANGLE_STEP);
        ang_next_d = (ang_sum_d > 17'(ANGLE_MAX)) ? 16'(ANGLE_MAX) : ang_sum_d[15:0];
`ifdef SCAN_AVG4_EN
        acc_sum_d  = acc_q + {2'b00, ir_data};
        smp_d      = acc_sum_d[IR_W+1:2];
`else
        smp_d      = ir_data;
`endif
        // strict compare: on a tie the earlier angle stays the winner
        take_d    = smp_d > max_val_q;
        win_ang_d = take_d ? angle_q : max_ang_q;
        win_val_d = take_d ? smp_d   : max_val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            angle_q      <= 16'(ANGLE_HOME);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ir_req_q     <= 1'b0;
            best_angle_q <= 16'(ANGLE_HOME);
            best_value_q <= '0;
            cnt_q        <= '0;
            max_ang_q    <= 16'(ANGLE_MIN);
            max_val_q    <= '0;
`ifdef SCAN_AVG4_EN
            k_q          <= '0;
            acc_q        <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            ir_req_q <= 1'b0;
            if (state_q == S_IDLE) begin
                if (start && !abort) begin
                    angle_q   <= 16'(ANGLE_MIN);
                    max_ang_q <= 16'(ANGLE_MIN);
                    max_val_q <= '0;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                    state_q   <= S_SETTLE;
`ifdef SCAN_AVG4_EN
                    k_q       <= '0;
                    acc_q     <= '0;
`endif
                end
            end else if (abort) begin
                // angle and results hold; any outstanding sample is dropped
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_SETTLE, S_PARK: begin
                        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                            cnt_q <= '0;
                            if (state_q == S_SETTLE) begin
                                ir_req_q <= 1'b1;
                                state_q  <= S_REQ;
                            end else begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_REQ: state_q <= S_WAIT;
                    S_WAIT: begin
                        if (ir_valid) begin
`ifdef SCAN_AVG4_EN
                            if (k_q != 2'd3) begin
                                acc_q    <= acc_sum_d;
                                k_q      <= k_q + 1'b1;
                                ir_req_q <= 1'b1;
                                state_q  <= S_REQ;
                            end else begin
                                acc_q <= '0;
                                k_q   <= '0;
`endif
                                max_ang_q <= win_ang_d;
                                max_val_q <= win_val_d;
                                cnt_q     <= '0;
                                if (angle_q == 16'(ANGLE_MAX)) begin
                                    // results published on entry to PARK
                                    angle_q      <= win_ang_d;
                                    best_angle_q <= win_ang_d;
                                    best_value_q <= win_val_d;
                                    state_q      <= S_PARK;
                                end else begin
                                    angle_q <= ang_next_d;
                                    state_q <= S_SETTLE;
                                end
`ifdef SCAN_AVG4_EN
                            end
`endif
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ir_req     = ir_req_q;
    assign angle      = angle_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_angle = best_angle_q;
    assign best_value = best_value_q;

endmodule

// File: tb/tb_servo_scan_ctrl.sv
module tb_servo_scan_ctrl;

`ifdef SCAN_AVG4_EN
    localparam int NS = 4;
`else
    localparam int NS = 1;
`endif

    typedef struct {
        int ang;
        int val;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start[2];
    logic        abort[2];
    logic        stray[2];
    logic        ir_req_a[2];
    logic        busy_a[2];
    logic        done_a[2];
    logic [15:0] angle_a[2];
    logic [15:0] best_angle_a[2];
    logic [11:0] best_value_a[2];

    int   total = 0;
    int   bad   = 0;
    int   exp_ang_q[2][$];
    res_t exp_res_q[2][$];
    int   last_best_a;
    int   last_best_v;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int samp(input int a, input int k);
`ifdef SCAN_AVG4_EN
        return (a == 0) ? ((k == 3) ? 12 : 8) : 0;
`else
        case (a)
            0:       return 10;
            5:       return 40;
            10:      return 25;
            15:      return 40;
            20:      return 5;
            default: return 30;
        endcase
`endif
    endfunction

    // push expected request angles and final result for a full sweep to mx
    task automatic plan_scan(input int i, input int mx);
        int a = 0;
        int ba = 0;
        int bv = 0;
        int v;
        res_t r;
        forever begin
            v = 0;
            for (int k = 0; k < NS; k++) begin
                exp_ang_q[i].push_back(a);
                v += samp(a, k);
            end
            if (NS == 4) v = v >> 2;
            if (v > bv) begin
                bv = v;
                ba = a;
            end
            if (a == mx) break;
            a = (a + 5 > mx) ? mx : a + 5;
        end
        r.ang = ba;
        r.val = bv;
        exp_res_q[i].push_back(r);
        last_best_a = ba;
        last_best_v = bv;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int MX = (g == 0) ? 20 : 22;
        logic        mv = 1'b0;
        logic [11:0] md = '0;
        logic        dv;
        logic [11:0] dd;
        int          cd = 0;
        int          kk = 0;
        int          last_a = -1;

        assign dv = mv | stray[g];
        assign dd = stray[g] ? 12'hFFF : md;

        servo_scan_ctrl #(
            .ANGLE_MIN(0),
            .ANGLE_MAX(MX),
            .ANGLE_STEP(5),
            .ANGLE_HOME(90),
            .SETTLE_CYCLES(4),
            .IR_W(12)
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .start(start[g]),
            .abort(abort[g]),
            .ir_req(ir_req_a[g]),
            .ir_valid(dv),
            .ir_data(dd),
            .angle(angle_a[g]),
            .busy(busy_a[g]),
            .done(done_a[g]),
            .best_angle(best_angle_a[g]),
            .best_value(best_value_a[g])
        );

        // IR front end: answers 3 cycles after each request
        always @(negedge clk) begin
            mv = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) mv = 1'b1;
            end
            if (ir_req_a[g]) begin
                if (int'(angle_a[g]) == last_a) kk++;
                else kk = 0;
                last_a = int'(angle_a[g]);
                md = 12'(samp(last_a, kk));
                cd = 3;
            end
        end

        // scoreboard: pop expectations as the DUT requests / finishes
        always @(negedge clk) begin
            int e;
            res_t r;
            if (ir_req_a[g]) begin
                chk("req_expected", exp_ang_q[g].size() != 0, 1);
                if (exp_ang_q[g].size() != 0) begin
                    e = exp_ang_q[g].pop_front();
                    chk("req_angle", angle_a[g], e);
                end
            end
            if (done_a[g]) begin
                chk("done_expected", exp_res_q[g].size() != 0, 1);
                if (exp_res_q[g].size() != 0) begin
                    r = exp_res_q[g].pop_front();
                    chk("best_angle", best_angle_a[g], r.ang);
                    chk("best_value", best_value_a[g], r.val);
                    chk("park_angle", angle_a[g], r.ang);
                    chk("busy_at_done", busy_a[g], 0);
                end
            end
        end
    end

    task automatic kick(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_scan(input int i, input bit glitch);
        int ndone = 0;
        bit ended = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start[i] = 1'b0;
            stray[i] = 1'b0;
            if (done_a[i]) ndone++;
            if (!busy_a[i]) begin
                ended = 1;
                break;
            end
            if (glitch) begin
                start[i] = (c % 13 == 5);
                stray[i] = (c == 1);
            end
        end
        start[i] = 1'b0;
        stray[i] = 1'b0;
        chk("scan_ended", ended, 1);
        repeat (12) begin
            @(negedge clk);
            if (done_a[i]) ndone++;
        end
        chk("done_count", ndone, 1);
        chk("req_left", exp_ang_q[i].size(), 0);
        chk("res_left", exp_res_q[i].size(), 0);
    endtask

    initial begin
        bit found = 0;
        int ndone = 0;
        int ba;
        int bv;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            abort[i] = 1'b0;
            stray[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_angle", angle_a[0], 90);
        chk("rst_busy", busy_a[0], 0);
        chk("rst_done", done_a[0], 0);
        chk("rst_req", ir_req_a[0], 0);
        chk("rst_best_angle", best_angle_a[0], 90);
        chk("rst_best_value", best_value_a[0], 0);

        // undisturbed scan
        plan_scan(0, 20);
        kick(0);
        chk("start_angle", angle_a[0], 0);
        chk("start_busy", busy_a[0], 1);
        wait_scan(0, 0);
        ba = last_best_a;
        bv = last_best_v;

        // abort in WAIT at angle 10 with a coincident ir_valid
        for (int a = 0; a < 10; a += 5)
            for (int k = 0; k < NS; k++) exp_ang_q[0].push_back(a);
        exp_ang_q[0].push_back(10);
        kick(0);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ir_req_a[0] && angle_a[0] == 16'd10) begin
                found = 1;
                break;
            end
        end
        chk("abort_reach", found, 1);
        repeat (3) @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_busy", busy_a[0], 0);
        chk("abort_angle", angle_a[0], 10);
        repeat (15) begin
            @(negedge clk);
            if (done_a[0]) ndone++;
        end
        chk("abort_done", ndone, 0);
        chk("abort_angle_hold", angle_a[0], 10);
        chk("abort_best_angle", best_angle_a[0], ba);
        chk("abort_best_value", best_value_a[0], bv);
        chk("abort_req_left", exp_ang_q[0].size(), 0);

        // repeated start and a stray sample in SETTLE
        plan_scan(0, 20);
        kick(0);
        wait_scan(0, 1);

        // ANGLE_MAX not on the step grid
        plan_scan(1, 22);
        kick(1);
        wait_scan(1, 0);

        // reset in the middle of a scan
        plan_scan(1, 22);
        kick(1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_angle", angle_a[1], 90);
        chk("mid_rst_busy", busy_a[1], 0);
        chk("mid_rst_best_angle", best_angle_a[1], 90);
        chk("mid_rst_best_value", best_value_a[1], 0);
        exp_ang_q[1].delete();
        exp_res_q[1].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a[1]) ndone++;
        end
        chk("mid_rst_done", ndone, 0);
        chk("mid_rst_idle", busy_a[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
